// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage. Accepts one instruction at a time from
// execute, runs at most one valid/ready bus transfer, and emits one registered
// writeback record per accepted instruction. Misaligned accesses and bus
// timeouts produce a writeback record with an exception flag set.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              req,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       store_data_in,
  input  logic [4:0]        rd_in,
  input  logic              rd_write_in,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall_out,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_value,
  output logic              exc_misalign,
  output logic              exc_bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic [4:0]    r_rd;
  logic          r_is_load;

  logic          w_is_load, w_is_store, w_is_mem, w_misalign, w_accept;
  logic          w_done, w_timeout;
  logic [3:0]    w_strb;
  logic [31:0]   w_wdata, w_load_val;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign stall_out = (r_state != IDLE);

  // Decode of the incoming instruction: access type, alignment, store lanes.
  always_comb begin
    w_is_load  = (opcode_in == OP_LOAD);
    w_is_store = (opcode_in == OP_STORE);
    w_is_mem   = w_is_load | w_is_store;
    w_accept   = (r_state == IDLE) && !stall_in;
    w_misalign = 1'b0;
    w_strb     = 4'b1111;
    w_wdata    = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << addr_in[1:0];
        w_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        w_misalign = addr_in[0];
        w_strb     = 4'b0011 << addr_in[1:0];
        w_wdata    = {2{store_data_in[15:0]}};
      end
      default: w_misalign = |addr_in[1:0];
    endcase
  end

  // Load lane selection and extension from the returned bus word.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = mem_rdata;
    endcase
  end

  // Next-state logic: enter BUS on an aligned memory op, leave on ready or timeout.
  always_comb begin
    w_done    = (r_state == BUS) && mem_ready;
    w_timeout = (r_state == BUS) && !mem_ready && (r_cnt == CNT_LAST);
    w_next    = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_mem && !w_misalign) w_next = BUS;
      BUS:     if (w_done || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge req) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Bus request, timeout counter and writeback record registers.
  always_ff @(posedge req) begin
    if (!rst_n) begin
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_value     <= '0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
      r_cnt        <= '0;
      r_f3         <= '0;
      r_off        <= '0;
      r_rd         <= '0;
      r_is_load    <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
      if (w_accept) begin
        r_f3      <= funct3_in;
        r_off     <= addr_in[1:0];
        r_rd      <= rd_in;
        r_is_load <= w_is_load;
        r_cnt     <= '0;
        if (!w_is_mem) begin
          wb_valid <= 1'b1;
          wb_we    <= rd_write_in & (|rd_in);
          wb_rd    <= rd_in;
          wb_value <= addr_in;
        end else if (w_misalign) begin
          wb_valid     <= 1'b1;
          wb_we        <= 1'b0;
          wb_rd        <= rd_in;
          wb_value     <= '0;
          exc_misalign <= 1'b1;
        end else begin
          mem_valid <= 1'b1;
          mem_we    <= w_is_store;
          mem_addr  <= ADDR_W'({addr_in[31:2], 2'b00});
          mem_wdata <= w_is_store ? w_wdata : '0;
          mem_wstrb <= w_is_store ? w_strb : '0;
        end
      end else if (w_done) begin
        mem_valid <= 1'b0;
        wb_valid  <= 1'b1;
        wb_we     <= r_is_load & (|r_rd);
        wb_rd     <= r_rd;
        wb_value  <= r_is_load ? w_load_val : '0;
      end else if (w_timeout) begin
        mem_valid <= 1'b0;
        wb_valid  <= 1'b1;
        wb_we     <= 1'b0;
        wb_rd     <= r_rd;
        wb_value  <= '0;
        exc_bus   <= 1'b1;
      end else if (r_state == BUS) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
